// File: rtl/msk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msk_pkg
// Description : Shared types and helpers for the masked-share recombiner.
//               - state_t   : recombiner FSM states (IDLE / FOLD / DONE)
//               - shidx     : flat bit index of bit i, share j (shares innermost)
//               - params_ok : parameter legality (d >= 1, count >= 1)
//               - k_width   : width of the share index register (min 1)
// Revision    : 1.0 - initial release
// ============================================================================
package msk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit i of share j lives at i*d + j in the flat bundle.
    function automatic int shidx(input int i, input int j, input int d);
        return i * d + j;
    endfunction

    function automatic bit params_ok(input int d, input int count);
        return (d >= 1) && (count >= 1);
    endfunction

    // The index has to reach d (one past the last share), hence d+1.
    function automatic int k_width(input int d);
        int w;
        w = $clog2(d + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : msk_pkg
`default_nettype wire

// File: rtl/msk_share_mux.sv
`default_nettype none
// ============================================================================
// Module      : msk_share_mux
// Description : Purely combinational share selector. Extracts the COUNT-bit
//               vector formed by share k of every bit of a flat shared bundle.
// Ports       : sh    in  [COUNT*D-1:0] flat shared bundle (shares innermost)
//               k     in  [K_W-1:0]     share index to extract
//               share out [COUNT-1:0]   share k of every bit (0 if k >= D)
// Revision    : 1.0 - initial release
// ============================================================================
module msk_share_mux
    import msk_pkg::*;
#(
    parameter int D     = 2,
    parameter int COUNT = 32,
    parameter int K_W   = 2
) (
    input  logic [COUNT*D-1:0] sh,
    input  logic [K_W-1:0]     k,
    output logic [COUNT-1:0]   share
);

    // One-hot compare per share so an out-of-range index simply yields zero.
    always_comb begin
        share = '0;
        for (int j = 0; j < D; j++) begin
            if (k == K_W'(j)) begin
                for (int i = 0; i < COUNT; i++) begin
                    share[i] = sh[shidx(i, j, D)];
                end
            end
        end
    end

endmodule : msk_share_mux
`default_nettype wire

// File: rtl/msk_share_unmask.sv
`default_nettype none
// ============================================================================
// Module      : msk_share_unmask
// Description : Stream-side recombiner for Boolean-masked data. Accepts one
//               bundle of COUNT bits in D shares, XOR-folds one share per
//               clock, and presents the unmasked word on a valid/ready port.
//               Share material is zeroized on every output handshake and reset.
// Ports       : clk        in   clock, rising edge
//               syncreset  in   synchronous active-high reset
//               in_valid   in   input bundle valid
//               in_ready   out  block can accept a bundle (IDLE only)
//               in_shares  in   [COUNT*D-1:0] shared bundle, index i*D+j
//               out_valid  out  out_data holds a recombined word
//               out_ready  in   downstream accepts out_data
//               out_data   out  [COUNT-1:0] unmasked word, 0 unless out_valid
//               busy       out  high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module msk_share_unmask
    import msk_pkg::*;
#(
    parameter int D     = 2,
    parameter int COUNT = 32
) (
    input  logic               clk,
    input  logic               syncreset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COUNT*D-1:0] in_shares,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT-1:0]   out_data,
    output logic               busy
);

    localparam int K_W = k_width(D);

    generate
        if (!params_ok(D, COUNT)) begin : g_param_check
            $error("msk_share_unmask: D and COUNT must both be >= 1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic               r_in_ready;
    logic [COUNT*D-1:0] r_sh;
    logic [COUNT-1:0]   r_acc;
    logic [K_W-1:0]     r_k;

    logic [COUNT-1:0]   w_share0;
    logic [COUNT-1:0]   w_share_k;
    logic               w_accept;
    logic               w_fold_last;

    // Share 0 is taken straight from the incoming bundle so the load cycle
    // already seeds the accumulator; later shares come from the buffer.
    msk_share_mux #(
        .D     (D),
        .COUNT (COUNT),
        .K_W   (K_W)
    ) u_share0_mux (
        .sh    (in_shares),
        .k     ('0),
        .share (w_share0)
    );

    msk_share_mux #(
        .D     (D),
        .COUNT (COUNT),
        .K_W   (K_W)
    ) u_sharek_mux (
        .sh    (r_sh),
        .k     (r_k),
        .share (w_share_k)
    );

    // r_in_ready is only ever set when the next state is IDLE, so it doubles
    // as the IDLE qualifier for acceptance and stays low for one cycle after
    // reset release (no input-to-output combinational path).
    assign w_accept    = r_in_ready & in_valid;
    assign w_fold_last = (r_k == K_W'(D - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (syncreset) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == ST_IDLE);
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (D > 1) ? ST_FOLD : ST_DONE;
                end
            end
            ST_FOLD: begin
                if (w_fold_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // The data gate uses the registered DONE decode so partial sums held in
    // the accumulator can never leak onto out_data.
    always_comb begin
        in_ready  = r_in_ready;
        out_valid = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
        out_data  = r_acc & {COUNT{r_state == ST_DONE}};
    end

    // ---------------- datapath: buffer, accumulator, index ----------------
    always_ff @(posedge clk) begin
        if (syncreset) begin
            r_sh  <= '0;
            r_acc <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sh  <= in_shares;
                        r_acc <= w_share0;
                        r_k   <= K_W'(1);
                    end
                end
                ST_FOLD: begin
                    r_acc <= r_acc ^ w_share_k;
                    r_k   <= r_k + K_W'(1);
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_sh  <= '0;
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                default: begin
                    r_sh  <= '0;
                    r_acc <= '0;
                    r_k   <= '0;
                end
            endcase
        end
    end

endmodule : msk_share_unmask
`default_nettype wire

// File: doc/msk_share_unmask.md
# msk_share_unmask

Stream-side recombiner for masked data: accepts one bundle of `count` bits in `d` Boolean shares over a valid/ready handshake and XOR-folds the shares. It folds one share per clock cycle, so no cycle combines more than the running sum with one new share. It then presents the unmasked word on a valid/ready output. It sits at the output boundary of the masked datapath, after the last masked register stage, and is the decoder counterpart of the input sharing logic.

## Interface
- `d`, 2: number of shares; must be ≥1.
- `count`, 32: number of unmasked bits per bundle.
- `clk` in 1: single clock; all state updates on the rising edge.
- `syncreset` in 1: synchronous, active-high reset.
- `in_valid` in 1: input bundle valid.
- `in_ready` out 1: block can accept a bundle.
- `in_shares` in count*d: shared bundle; bit i, share j sits at index i*d+j (shares innermost).
- `out_valid` out 1: `out_data` holds a recombined word.
- `out_ready` in 1: downstream accepts `out_data`.
- `out_data` out count: unmasked word; forced to 0 whenever `out_valid`=0.
- `busy` out 1: high in every state except IDLE.

## Operation
- Registers:
  - share buffer `sh` (count*d bits).
  - accumulator `acc` (count bits).
  - share index `k` (width $clog2(d+1), min 1).
  - state.
- States and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, capture `in_shares` into `sh` and load `acc` with share 0 of every bit. Set `k`=1. Go to FOLD if d>1, else to DONE.
  - FOLD: `acc` <= `acc` ^ share `k` of every bit, and `k`++. After folding share d-1, go to DONE.
  - DONE: `out_valid`=1 and `out_data`=`acc`. Stay in DONE while `out_ready`=0, holding `acc` stable. On `out_ready`=1, zero `sh`, `acc` and `k`, then go to IDLE.
- `in_ready` is high only in IDLE and not while `syncreset`=1. A bundle offered in any other state is not accepted. The upstream side must hold `in_valid` and `in_shares` until the handshake completes.
- Partial sums never reach `out_data`. The output gating is AND-ing with the DONE decode, taken from a registered state bit.
- Zeroization: share material is cleared on every output handshake and on reset. No stale shares survive into the next bundle.
- `syncreset` has priority over every event, in every state. On the next edge:
  - state becomes IDLE.
  - `sh`, `acc` and `k` become 0.
  - an in-flight bundle is discarded with no output.

## Timing
- Reset values: `in_ready`=0 while `syncreset` is high, then 1 in the first cycle after release. `out_valid`=0, `out_data`=0, `busy`=0.
- Latency: a bundle accepted in cycle c gives `out_valid`=1 from cycle c+d (d-1 FOLD cycles plus one load cycle).
- Throughput: at most one bundle per d+1 cycles when `out_ready` is tied high. The first `in_ready` after a handshake is in cycle c+d+1.
- There are no combinational paths from any input to any output. `in_ready`, `out_valid` and `busy` decode registered state only.
- Special cases:
  - `in_valid` asserted in the cycle syncreset deasserts: not accepted, because `in_ready`=0.
  - d=1: FOLD is skipped and `out_data` equals share 0.

## Structure
- Shared package `msk_pkg`:
  - state enum (IDLE/FOLD/DONE).
  - share-index function `shidx(i,j)=i*d+j`.
  - parameter legality check (d≥1, count≥1).
- One sub-module, `msk_share_mux`: purely combinational. Takes the `sh` buffer and `k` and returns the count-bit vector of share `k`, built with `shidx`. The top holds the FSM, `acc`, handshakes and zeroization.

## Test plan
- d=2, count=32, word 0xDEADBEEF, share0=0x12345678, share1=0xCC99E897 (interleaved per `shidx`). Accept in cycle c → `out_valid` first high in c+2 with `out_data`=0xDEADBEEF. `out_data`=0 in c+1.
- d=3, count=32, shares 0xA5A5A5A5, 0x0F0F0F0F, 0x00000000 → 0xAAAAAAAA. `out_valid` from c+3. Internal `acc` equals 0xA5A5A5A5 after the load edge, then 0xAAAAAAAA after the first fold edge and after the second.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE. Expected:
  - `out_data` stable.
  - `in_ready`=0 throughout, and a second `in_valid` is ignored.
  - on release, exactly one handshake, then `in_ready`=1 the next cycle and `sh`=0.
- Reset mid-operation: assert `syncreset` during FOLD with d=3. Next cycle: `out_valid`=0, `busy`=0, `sh`=`acc`=0. No output word ever appears for the aborted bundle.
- Back-to-back: two bundles with `out_ready` tied 1, d=2. Outputs appear in cycles c+2 and c+5; every other cycle shows `out_data`=0.
- d=1, count=8: share 0x3C accepted in c → `out_data`=0x3C with `out_valid` in c+1.
